// File: rtl/atomrv_exmem.sv
// atomrv_exmem: execute/memory back-end of the atomRV core.
// Stage 1 registers the ALU / branch / jump result and the redirect.
// Stage 2 performs the DCCM load/store and produces write-back data.
// The ICCM provides a combinational read port and a synchronous write port.
// Optional build macro: ATOMRV_MISALIGN_CHK_EN. When it is defined, a load or
// store whose address is not word aligned raises err_o, a misaligned store is
// dropped, and a misaligned load does not write back.
module atomrv_exmem #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5,
    parameter int ALU_OP           = 6,
    parameter int DCCM_DEPTH       = 256,
    parameter int ICCM_DEPTH       = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [ALU_OP-1:0]           ALUop_i,
    input  logic [DATAWIDTH-1:0]        PC_i,
    input  logic [DATAWIDTH-1:0]        operand_A_i,
    input  logic [DATAWIDTH-1:0]        operand_B_i,
    input  logic [DATAWIDTH-1:0]        immed_i,
    input  logic [DATAWIDTH-1:0]        address_i,
    input  logic [DATAWIDTH-1:0]        R2_i,
    input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
    input  logic                        RWR_EN_i,
    input  logic                        DR_EN_i,
    input  logic                        DWR_EN_i,
    input  logic                        SB_EN_i,
    input  logic                        UJE_i,
    input  logic                        JALRE_i,
    input  logic                        U_EN_i,
    input  logic                        LUI_EN_i,
    output logic [DATAWIDTH-1:0]        result_o,
    output logic [DATAWIDTH-1:0]        PC_o,
    output logic                        BE_o,
    output logic [DATAWIDTH-1:0]        WR_o,
    output logic [REG_ADRESS_WIDTH-1:0] RD_o,
    output logic                        RWR_EN_o,
    output logic                        DR_EN_o,
    output logic [DATAWIDTH-1:0]        DT_o,
    output logic                        err_o,
    input  logic [DATAWIDTH-1:0]        iaddr_i,
    input  logic [DATAWIDTH-1:0]        idata_i,
    input  logic                        IR_EN_i,
    input  logic                        IWR_EN_i,
    output logic [DATAWIDTH-1:0]        instr_o
);

    localparam int DIDX_W = $clog2(DCCM_DEPTH);
    localparam int IIDX_W = $clog2(ICCM_DEPTH);

    localparam logic [ALU_OP-1:0] OP_ADD  = ALU_OP'(0);
    localparam logic [ALU_OP-1:0] OP_SUB  = ALU_OP'(1);
    localparam logic [ALU_OP-1:0] OP_SLL  = ALU_OP'(2);
    localparam logic [ALU_OP-1:0] OP_SLT  = ALU_OP'(3);
    localparam logic [ALU_OP-1:0] OP_SLTU = ALU_OP'(4);
    localparam logic [ALU_OP-1:0] OP_XOR  = ALU_OP'(5);
    localparam logic [ALU_OP-1:0] OP_SRL  = ALU_OP'(6);
    localparam logic [ALU_OP-1:0] OP_SRA  = ALU_OP'(7);
    localparam logic [ALU_OP-1:0] OP_OR   = ALU_OP'(8);
    localparam logic [ALU_OP-1:0] OP_AND  = ALU_OP'(9);
    localparam logic [ALU_OP-1:0] OP_BEQ  = ALU_OP'(16);
    localparam logic [ALU_OP-1:0] OP_BNE  = ALU_OP'(17);
    localparam logic [ALU_OP-1:0] OP_BLT  = ALU_OP'(18);
    localparam logic [ALU_OP-1:0] OP_BGE  = ALU_OP'(19);
    localparam logic [ALU_OP-1:0] OP_BLTU = ALU_OP'(20);
    localparam logic [ALU_OP-1:0] OP_BGEU = ALU_OP'(21);

    // Execute-stage combinational values
    logic [DATAWIDTH-1:0] alu_res;
    logic                 br_taken;
    logic [DATAWIDTH-1:0] jalr_sum;
    logic [DATAWIDTH-1:0] ex_result;
    logic [DATAWIDTH-1:0] ex_pc;
    logic                 ex_be;
    logic [4:0]           shamt;

    // Execute-stage pipeline registers that feed the memory stage
    logic [DATAWIDTH-1:0]        addr_q;
    logic [DATAWIDTH-1:0]        r2_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_q;
    logic                        rwr_en_q;
    logic                        dr_en_q;
    logic                        dwr_en_q;

    // Memory-stage signals
    logic [DATAWIDTH-1:0] dccm [DCCM_DEPTH];
    logic [DATAWIDTH-1:0] iccm [ICCM_DEPTH];
    logic [DIDX_W-1:0]    didx;
    logic [IIDX_W-1:0]    iidx;
    logic                 misaligned;
    logic                 err_q;
    logic                 unused_addr_bits;

    assign shamt    = operand_B_i[4:0];
    assign jalr_sum = operand_A_i + immed_i;

    // ALU datapath; undefined opcodes produce zero
    always_comb begin
        alu_res = '0;
        case (ALUop_i)
            OP_ADD:  alu_res = operand_A_i + operand_B_i;
            OP_SUB:  alu_res = operand_A_i - operand_B_i;
            OP_SLL:  alu_res = operand_A_i << shamt;
            OP_SLT:  alu_res = {{(DATAWIDTH-1){1'b0}}, $signed(operand_A_i) < $signed(operand_B_i)};
            OP_SLTU: alu_res = {{(DATAWIDTH-1){1'b0}}, operand_A_i < operand_B_i};
            OP_XOR:  alu_res = operand_A_i ^ operand_B_i;
            OP_SRL:  alu_res = operand_A_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(operand_A_i) >>> shamt);
            OP_OR:   alu_res = operand_A_i | operand_B_i;
            OP_AND:  alu_res = operand_A_i & operand_B_i;
            default: alu_res = '0;
        endcase
    end

    // Branch condition evaluation on operand A versus operand B
    always_comb begin
        br_taken = 1'b0;
        case (ALUop_i)
            OP_BEQ:  br_taken = (operand_A_i == operand_B_i);
            OP_BNE:  br_taken = (operand_A_i != operand_B_i);
            OP_BLT:  br_taken = ($signed(operand_A_i) < $signed(operand_B_i));
            OP_BGE:  br_taken = ($signed(operand_A_i) >= $signed(operand_B_i));
            OP_BLTU: br_taken = (operand_A_i < operand_B_i);
            OP_BGEU: br_taken = (operand_A_i >= operand_B_i);
            default: br_taken = 1'b0;
        endcase
    end

    // Result/redirect selection: LUI > AUIPC > JAL > JALR > branch > ALU
    always_comb begin
        ex_result = '0;
        ex_pc     = '0;
        ex_be     = 1'b0;
        if (LUI_EN_i) begin
            ex_result = immed_i;
        end else if (U_EN_i) begin
            ex_result = PC_i + immed_i;
        end else if (UJE_i) begin
            ex_result = PC_i + DATAWIDTH'(4);
            ex_pc     = PC_i + immed_i;
            ex_be     = 1'b1;
        end else if (JALRE_i) begin
            ex_result = PC_i + DATAWIDTH'(4);
            ex_pc     = {jalr_sum[DATAWIDTH-1:1], 1'b0};
            ex_be     = 1'b1;
        end else if (SB_EN_i) begin
            ex_pc     = PC_i + immed_i;
            ex_be     = br_taken;
        end else begin
            ex_result = alu_res;
        end
    end

    // Execute-stage register bank
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_o <= '0;
            PC_o     <= '0;
            BE_o     <= 1'b0;
            addr_q   <= '0;
            r2_q     <= '0;
            rd_q     <= '0;
            rwr_en_q <= 1'b0;
            dr_en_q  <= 1'b0;
            dwr_en_q <= 1'b0;
        end else begin
            result_o <= ex_result;
            PC_o     <= ex_pc;
            BE_o     <= ex_be;
            addr_q   <= address_i;
            r2_q     <= R2_i;
            rd_q     <= RD_i;
            rwr_en_q <= RWR_EN_i;
            dr_en_q  <= DR_EN_i;
            dwr_en_q <= DWR_EN_i;
        end
    end

    // Upper address bits are dropped so accesses wrap around the memory
    assign didx = addr_q[DIDX_W+1:2];
    assign iidx = iaddr_i[IIDX_W+1:2];

`ifdef ATOMRV_MISALIGN_CHK_EN
    assign misaligned = (dr_en_q || dwr_en_q) && (addr_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign unused_addr_bits = ^{iaddr_i[DATAWIDTH-1:IIDX_W+2], iaddr_i[1:0],
                                addr_q[DATAWIDTH-1:DIDX_W+2], addr_q[1:0]};

    // DCCM write port; a store in the memory stage lands at this edge
    always_ff @(posedge clk_i) begin
        if (rst_ni && dwr_en_q && !misaligned) begin
            dccm[didx] <= r2_q;
        end
    end

    // Memory-stage register bank and load data selection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            WR_o     <= '0;
            DT_o     <= '0;
            RD_o     <= '0;
            RWR_EN_o <= 1'b0;
            DR_EN_o  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            WR_o     <= dr_en_q ? dccm[didx] : result_o;
            DT_o     <= dr_en_q ? dccm[didx] : '0;
            RD_o     <= rd_q;
            RWR_EN_o <= rwr_en_q && !(dr_en_q && misaligned);
            DR_EN_o  <= dr_en_q;
            err_q    <= misaligned;
        end
    end

    assign err_o = err_q;

    // ICCM write port; a same-cycle read still returns the old word
    always_ff @(posedge clk_i) begin
        if (IWR_EN_i) begin
            iccm[iidx] <= idata_i;
        end
    end

    assign instr_o = IR_EN_i ? iccm[iidx] : '0;

endmodule

// File: tb/tb_atomrv_exmem.sv
// tb_atomrv_exmem: directed and randomized checks of atomrv_exmem against a
// behavioural model of the execute/memory pipeline and both memories.
module tb_atomrv_exmem;

    localparam int W = 32;

    // Clock and reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT inputs
    logic [5:0]   alu_op;
    logic [W-1:0] pc, op_a, op_b, immed, address, r2, iaddr, idata;
    logic [4:0]   rd;
    logic         rwr_en, dr_en, dwr_en, sb_en, uje, jalre, u_en, lui_en, ir_en, iwr_en;

    // DUT outputs
    logic [W-1:0] result_o, pc_o, wr_o, dt_o, instr_o;
    logic [4:0]   rd_o;
    logic         be_o, rwr_en_o, dr_en_o, err_o;

    atomrv_exmem dut (
        .clk_i(clk), .rst_ni(rst_n), .ALUop_i(alu_op), .PC_i(pc),
        .operand_A_i(op_a), .operand_B_i(op_b), .immed_i(immed),
        .address_i(address), .R2_i(r2), .RD_i(rd), .RWR_EN_i(rwr_en),
        .DR_EN_i(dr_en), .DWR_EN_i(dwr_en), .SB_EN_i(sb_en), .UJE_i(uje),
        .JALRE_i(jalre), .U_EN_i(u_en), .LUI_EN_i(lui_en),
        .result_o(result_o), .PC_o(pc_o), .BE_o(be_o), .WR_o(wr_o),
        .RD_o(rd_o), .RWR_EN_o(rwr_en_o), .DR_EN_o(dr_en_o), .DT_o(dt_o),
        .err_o(err_o), .iaddr_i(iaddr), .idata_i(idata), .IR_EN_i(ir_en),
        .IWR_EN_i(iwr_en), .instr_o(instr_o)
    );

    // Scoreboard counters and single checking task
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model state
    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] r2;
        logic [W-1:0] res;
        logic [4:0]   rd;
        logic         rwr;
        logic         dr;
        logic         dwr;
    } rec_t;

    rec_t         pend;
    logic [W-1:0] dmem_m [256];
    logic [W-1:0] imem_m [256];
    logic [W-1:0] m_result, m_pc, m_dt;
    logic         m_be, m_rwr, m_dr, m_err;
    logic [4:0]   m_rd;
    logic [W-1:0] exp_q[$];

    function automatic int word_of(input logic [W-1:0] a);
        return int'((a >> 2) % 256);
    endfunction

    // What the execute stage should produce for the inputs currently driven
    function automatic void ref_exec(output logic [W-1:0] res, output logic [W-1:0] pcn, output logic be);
        logic [4:0] sh;
        sh  = op_b[4:0];
        res = '0;
        pcn = '0;
        be  = 1'b0;
        if (lui_en) res = immed;
        else if (u_en) res = pc + immed;
        else if (uje) begin
            res = pc + 32'd4; pcn = pc + immed; be = 1'b1;
        end else if (jalre) begin
            res = pc + 32'd4; pcn = (op_a + immed) & 32'hFFFF_FFFE; be = 1'b1;
        end else if (sb_en) begin
            pcn = pc + immed;
            case (alu_op)
                6'd16: be = (op_a == op_b);
                6'd17: be = (op_a != op_b);
                6'd18: be = ($signed(op_a) < $signed(op_b));
                6'd19: be = !($signed(op_a) < $signed(op_b));
                6'd20: be = (op_a < op_b);
                6'd21: be = !(op_a < op_b);
                default: be = 1'b0;
            endcase
        end else begin
            case (alu_op)
                6'd0: res = op_a + op_b;
                6'd1: res = op_a + ~op_b + 32'd1;
                6'd2: res = op_a << sh;
                6'd3: res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                6'd4: res = (op_a < op_b) ? 32'd1 : 32'd0;
                6'd5: res = op_a ^ op_b;
                6'd6: res = op_a >> sh;
                6'd7: res = $unsigned($signed(op_a) >>> sh);
                6'd8: res = op_a | op_b;
                6'd9: res = op_a & op_b;
                default: res = '0;
            endcase
        end
    endfunction

    // Advance the model by one rising edge
    task automatic model_edge();
        logic [W-1:0] res, pcn;
        logic         be, mis;
        int           idx;
        if (iwr_en) imem_m[word_of(iaddr)] = idata;
        if (!rst_n) begin
            m_result = '0; m_pc = '0; m_be = 1'b0;
            m_dt = '0; m_rd = '0; m_rwr = 1'b0; m_dr = 1'b0; m_err = 1'b0;
            pend = '0;
            exp_q.push_back('0);
            return;
        end
        idx = word_of(pend.addr);
        mis = 1'b0;
`ifdef ATOMRV_MISALIGN_CHK_EN
        mis = (pend.dr || pend.dwr) && (pend.addr % 4 != 0);
`endif
        m_rd  = pend.rd;
        m_dr  = pend.dr;
        m_err = mis;
        m_rwr = pend.rwr && !(pend.dr && mis);
        if (pend.dr) begin
            m_dt = dmem_m[idx];
            exp_q.push_back(dmem_m[idx]);
        end else begin
            m_dt = '0;
            exp_q.push_back(pend.res);
        end
        if (pend.dwr && !mis) dmem_m[idx] = pend.r2;
        ref_exec(res, pcn, be);
        m_result = res;
        m_pc     = pcn;
        m_be     = be;
        pend = '{addr: address, r2: r2, res: res, rd: rd, rwr: rwr_en, dr: dr_en, dwr: dwr_en};
    endtask

    // Compare every output against the model
    task automatic check_all();
        logic [W-1:0] e_wr, e_instr;
        e_wr    = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        e_instr = ir_en ? imem_m[word_of(iaddr)] : '0;
        check_val("result", result_o, m_result);
        check_val("pc_out", pc_o, m_pc);
        check_val("be", {31'd0, be_o}, {31'd0, m_be});
        check_val("wr", wr_o, e_wr);
        check_val("dt", dt_o, m_dt);
        check_val("rd", {27'd0, rd_o}, {27'd0, m_rd});
        check_val("rwr_en", {31'd0, rwr_en_o}, {31'd0, m_rwr});
        check_val("dr_en", {31'd0, dr_en_o}, {31'd0, m_dr});
        check_val("err", {31'd0, err_o}, {31'd0, m_err});
        check_val("instr", instr_o, e_instr);
    endtask

    // One clock: edge, model update, check on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Driver tasks
    task automatic clear_in();
        alu_op = '0; pc = '0; op_a = '0; op_b = '0; immed = '0; address = '0;
        r2 = '0; iaddr = '0; idata = '0; rd = '0;
        rwr_en = 0; dr_en = 0; dwr_en = 0; sb_en = 0; uje = 0; jalre = 0;
        u_en = 0; lui_en = 0; ir_en = 0; iwr_en = 0;
    endtask

    task automatic drive_alu(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        clear_in();
        alu_op = op; op_a = a; op_b = b;
    endtask

    task automatic drive_store(input logic [W-1:0] a, input logic [W-1:0] d);
        clear_in();
        dwr_en = 1'b1; address = a; r2 = d;
    endtask

    task automatic drive_load(input logic [W-1:0] a, input logic [4:0] dst);
        clear_in();
        dr_en = 1'b1; rwr_en = 1'b1; address = a; rd = dst;
    endtask

    task automatic random_in();
        int kind;
        clear_in();
        kind    = $urandom_range(0, 5);
        alu_op  = 6'($urandom_range(0, 23));
        pc      = $urandom;
        op_a    = $urandom;
        op_b    = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
        immed   = $urandom;
        address = ($urandom << 10) | $urandom_range(0, 127);
        r2      = $urandom;
        rd      = 5'($urandom);
        rwr_en  = 1'($urandom);
        case (kind)
            0: alu_op = 6'($urandom_range(0, 15));
            1: sb_en = 1'b1;
            2: begin
                lui_en = 1'($urandom); u_en = 1'($urandom); uje = 1'($urandom);
                jalre = 1'($urandom); sb_en = 1'($urandom);
            end
            3: dwr_en = 1'b1;
            4: dr_en = 1'b1;
            default: begin
                dr_en = 1'($urandom); dwr_en = 1'($urandom);
            end
        endcase
        ir_en  = 1'($urandom);
        iaddr  = ($urandom << 10) | $urandom_range(0, 127);
        iwr_en = ($urandom_range(0, 3) == 0);
        idata  = $urandom;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus and report
    initial begin
        clear_in();
        rst_n = 1'b0;
        step();
        step();
        check_val("reset_result", result_o, 32'd0);
        check_val("reset_wr", wr_o, 32'd0);
        check_val("reset_rwr", {31'd0, rwr_en_o}, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check_val("idle_result", result_o, 32'd0);
        check_val("idle_pc", pc_o, 32'd0);

        // Give both memories known contents in the region the bench uses
        for (int i = 0; i < 32; i++) begin
            drive_store(32'(i * 4), $urandom);
            iwr_en = 1'b1; iaddr = 32'(i * 4); idata = $urandom;
            step();
        end
        clear_in();
        step();
        step();

        // ALU corner cases
        drive_alu(6'd0, 32'hFFFF_FFF0, 32'h10); step();
        check_val("add_wrap", result_o, 32'd0);
        drive_alu(6'd3, 32'hFFFF_FFF0, 32'h10); step();
        check_val("slt", result_o, 32'd1);
        drive_alu(6'd4, 32'hFFFF_FFF0, 32'h10); step();
        check_val("sltu", result_o, 32'd0);
        drive_alu(6'd7, 32'hFFFF_FFF0, 32'h4); step();
        check_val("sra", result_o, 32'hFFFF_FFFF);

        // Branches and JALR
        clear_in(); sb_en = 1'b1; alu_op = 6'd16; pc = 32'h100; immed = 32'h20;
        op_a = 32'h55; op_b = 32'h55; step();
        check_val("beq_be", {31'd0, be_o}, 32'd1);
        check_val("beq_pc", pc_o, 32'h120);
        alu_op = 6'd17; step();
        check_val("bne_be", {31'd0, be_o}, 32'd0);
        clear_in(); jalre = 1'b1; pc = 32'h100; op_a = 32'h203; immed = 32'h0; step();
        check_val("jalr_pc", pc_o, 32'h202);
        check_val("jalr_res", result_o, 32'h104);

        // DCCM store then back-to-back load
        drive_store(32'h40, 32'hDEAD_BEEF); step();
        drive_load(32'h40, 5'd5); step();
        clear_in(); step();
        check_val("ld_wr", wr_o, 32'hDEAD_BEEF);
        check_val("ld_dt", dt_o, 32'hDEAD_BEEF);
        check_val("ld_rd", {27'd0, rd_o}, 32'd5);
        check_val("ld_rwr", {31'd0, rwr_en_o}, 32'd1);

        // ICCM write then read
        clear_in(); iwr_en = 1'b1; iaddr = 32'h8; idata = 32'h0050_0093; step();
        clear_in(); ir_en = 1'b1; iaddr = 32'h8; #1;
        check_val("iccm_rd", instr_o, 32'h0050_0093);
        ir_en = 1'b0; #1;
        check_val("iccm_off", instr_o, 32'd0);
        step();

`ifdef ATOMRV_MISALIGN_CHK_EN
        drive_store(32'h41, 32'h1234_5678); step();
        clear_in(); step();
        check_val("mis_err", {31'd0, err_o}, 32'd1);
        drive_load(32'h40, 5'd7); step();
        clear_in(); step();
        check_val("mis_keep", dt_o, 32'hDEAD_BEEF);
        check_val("mis_clr", {31'd0, err_o}, 32'd0);
`endif

        // Randomized traffic with one reset pulse in the middle
        for (int i = 0; i < 600; i++) begin
            random_in();
            rst_n = (i != 300);
            step();
        end
        rst_n = 1'b1;
        clear_in();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/atomrv_exmem.md
Name: atomrv_exmem

Overview:
- Execute/memory back-end of the atomRV core: registered ALU/branch stage, word-addressed data memory (DCCM) stage, and instruction memory (ICCM).
- Sits between the decoder (operands, immediates, control enables) and the fetch unit (instruction word, branch redirect) and register file (write-back).

Parameters:
DATAWIDTH, 32, data/address width
REG_ADRESS_WIDTH, 5, register index width
ALU_OP, 6, ALU opcode width
DCCM_DEPTH, 256, data memory words
ICCM_DEPTH, 256, instruction memory words

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
ALUop_i  in  ALU_OP  operation code
PC_i  in  DATAWIDTH  PC of instruction in execute
operand_A_i / operand_B_i  in  DATAWIDTH  rs1 / pre-muxed rs2-or-imm
immed_i  in  DATAWIDTH  immediate for targets, LUI, AUIPC
address_i  in  DATAWIDTH  load/store byte address
R2_i  in  DATAWIDTH  store data
RD_i  in  REG_ADRESS_WIDTH  destination register
RWR_EN_i, DR_EN_i, DWR_EN_i  in  1  reg-write, load, store enables
SB_EN_i, UJE_i, JALRE_i, U_EN_i, LUI_EN_i  in  1  branch, JAL, JALR, AUIPC, LUI
result_o  out  DATAWIDTH  execute-stage result
PC_o  out  DATAWIDTH  redirect target
BE_o  out  1  redirect taken
WR_o  out  DATAWIDTH  write-back data
RD_o  out  REG_ADRESS_WIDTH  write-back register
RWR_EN_o  out  1  write-back enable
DR_EN_o  out  1  write-back carries load data
DT_o  out  DATAWIDTH  raw load data
err_o  out  1  misaligned access flag
iaddr_i  in  DATAWIDTH  ICCM byte address
idata_i  in  DATAWIDTH  ICCM write data
IR_EN_i / IWR_EN_i  in  1  ICCM read / write enable
instr_o  out  DATAWIDTH  instruction word

Behaviour:
- Reset: all registered outputs 0 while rst_ni=0 at a clock edge; memory contents are not cleared.
- Execute stage, 1-cycle latency; result_o/PC_o/BE_o plus internal addr, R2, RD, RWR_EN, DR_EN, DWR_EN registered.
- ALUop encodings: 0 ADD, 1 SUB, 2 SLL (B[4:0]), 3 SLT signed, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Any other code gives result 0.
- Branch compares: 16 BEQ, 17 BNE, 18 BLT, 19 BGE, 20 BLTU, 21 BGEU, on A vs B.
- Priority: LUI_EN_i → result=immed. U_EN_i → result=PC+immed. UJE_i → result=PC+4, PC_o=PC+immed, BE=1. JALRE_i → result=PC+4, PC_o=(A+immed)&~1, BE=1. SB_EN_i → result 0, PC_o=PC+immed, BE=compare. Else ALU op, BE=0, PC_o=0.
- All arithmetic is modulo 2^32. Shifts use amount[4:0].
- Memory stage, one further cycle. Word index = addr[log2(DCCM_DEPTH)+1:2]; upper address bits are ignored (wrap-around).
- Store (registered DWR_EN) writes R2 at the clock edge.
- Load (registered DR_EN) samples mem[idx] at the edge. DT_o = load data, else 0. WR_o = load ? data : result_o.
- RD_o, RWR_EN_o and DR_EN_o are the execute-stage values delayed one cycle.
- A store followed next cycle by a load to the same address returns the new data.
- ICCM read is combinational: instr_o = IR_EN_i ? mem[iaddr_i word] : 0.
- ICCM write is synchronous: mem[iaddr] <= idata_i when IWR_EN_i. Simultaneous read of the written word shows the old data until the edge.

Optional Feature:
- ATOMRV_MISALIGN_CHK_EN defined:
  - A registered load/store with addr[1:0]≠0 sets err_o=1 in the memory stage.
  - A misaligned store is suppressed.
  - A misaligned load forces RWR_EN_o=0.
- Undefined: err_o tied 0 and addr[1:0] are ignored.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles → all outputs 0. After release with no enables asserted, outputs stay 0.
- ALU: A=0xFFFFFFF0, B=0x10, op ADD → result_o=0 one cycle later. SLT=1, SLTU=0, SRA by 4 gives 0xFFFFFFFF.
- Branch/jump:
  - PC=0x100, imm=0x20, BEQ with A=B → BE_o=1, PC_o=0x120.
  - BNE with A=B → BE_o=0.
  - JALR with A=0x203, imm=0 → PC_o=0x202, result=0x104.
- DCCM: store 0xDEADBEEF to 0x40, then load 0x40 with RD=5 → two cycles after the load, WR_o=DT_o=0xDEADBEEF, RD_o=5, RWR_EN_o=1.
- ICCM:
  - Write 0x00500093 at 0x8 → next cycle IR_EN_i=1 gives instr_o=0x00500093.
  - IR_EN_i=0 → instr_o=0.
- Misalign (macro on): store to 0x41 → err_o=1 and word 0x40 is unchanged.
